// File: rtl/neuron_mac_q88.sv
// Streaming Q8.8 multiply-accumulate neuron stage: N_INPUTS beats plus bias, rescaled and saturated to Q8.8.
// Optional macro NEURON_MAC_ROUND_EN selects round-half-up instead of truncation toward -inf.
module neuron_mac_q88 #(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 40,
    parameter int FRAC     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_x,
    input  logic signed [15:0] in_w,
    input  logic signed [15:0] bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_x,
    output logic               out_sat
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_NEG = ACC_W'(-32768);
`ifdef NEURON_MAC_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC - 1);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {ST_ACCUM, ST_FINAL, ST_OUT} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [15:0]       out_x_q, out_x_d;
    logic                     out_sat_q, out_sat_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  shifted;

    always_comb begin
        prod     = in_x * in_w;
        prod_ext = ACC_W'(prod);
        bias_ext = ACC_W'(bias) <<< FRAC;
        rounded  = acc_q + RND;
        shifted  = rounded >>> FRAC;

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_x_d     = out_x_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    // The first beat of a result seeds the accumulator with the bias instead of the old sum.
                    acc_d = (cnt_q == '0) ? (prod_ext + bias_ext) : (acc_q + prod_ext);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_FINAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FINAL: begin
                if (shifted > MAX_POS) begin
                    out_x_d   = 16'sh7fff;
                    out_sat_d = 1'b1;
                end else if (shifted < MIN_NEG) begin
                    out_x_d   = 16'sh8000;
                    out_sat_d = 1'b1;
                end else begin
                    out_x_d   = shifted[15:0];
                    out_sat_d = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_x_q     <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_x_q     <= out_x_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac_q88.sv
// Directed bench for neuron_mac_q88 with an arithmetic reference model and per-cycle output checking.
module tb_neuron_mac_q88;

    localparam int N = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_x;
    logic signed [15:0] in_w;
    logic signed [15:0] bias;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_x;
    logic               out_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int x;
        bit sat;
    } result_t;
    result_t exp_q[$];

    neuron_mac_q88 #(.N_INPUTS(N), .ACC_W(40), .FRAC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: exact integer sum of products plus scaled bias, then shift and clip.
    function automatic result_t model(input int xs[N], input int ws[N], input int b);
        longint  acc;
        longint  r;
        result_t res;
        acc = longint'(b) * 256;
        for (int i = 0; i < N; i++) acc += longint'(xs[i]) * longint'(ws[i]);
`ifdef NEURON_MAC_ROUND_EN
        acc += 128;
`endif
        r = acc >>> 8;
        if (r > 32767) begin
            res.x = 32767; res.sat = 1'b1;
        end else if (r < -32768) begin
            res.x = -32768; res.sat = 1'b1;
        end else begin
            res.x = int'(r); res.sat = 1'b0;
        end
        return res;
    endfunction

    // Compare process: every cycle a result is presented it must match the model's oldest entry.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("model_out_x", out_x, exp_q[0].x);
                check("model_out_sat", out_sat, exp_q[0].sat);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end

    task automatic drive_beat(input int x, input int w, input int b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_x = 16'(x); in_w = 16'(w); bias = 16'(b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int xs[N], input int ws[N], input int b, input int gap);
        result_t r;
        r = model(xs, ws, b);
        exp_q.push_back(r);
        $display("send: bias=%0d gap=%0d model out_x=%0d sat=%0d", b, gap, r.x, r.sat);
        for (int i = 0; i < N; i++) drive_beat(xs[i], ws[i], b, gap);
    endtask

    task automatic recv(input string name, input int ex, input bit esat, input int hold);
        int n;
        logic signed [15:0] held;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check({name, "_valid_timeout"}, 0, 1);
        check({name, "_out_x"}, out_x, ex);
        check({name, "_out_sat"}, out_sat, esat);
        $display("recv %s: out_x=%0d out_sat=%0d", name, out_x, out_sat);
        held = out_x;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_in_ready"}, in_ready, 0);
            check({name, "_hold_out_x"}, out_x, held);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_drop_valid"}, out_valid, 0);
        check({name, "_in_ready_after"}, in_ready, 1);
        check({name, "_out_x_retained"}, out_x, held);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    int xs[N];
    int ws[N];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; bias = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_x", out_x, 0);
        check("reset_out_sat", out_sat, 0);
        rst = 1'b0;

        // Unity sum with latency check: FINAL cycle after the last beat, result the cycle after.
        for (int i = 0; i < N; i++) begin xs[i] = 256; ws[i] = 256; end
        send_vec(xs, ws, 0, 0);
        check("latency_final_valid", out_valid, 0);
        check("latency_final_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("latency_out_valid", out_valid, 1);
        recv("unity", 2048, 1'b0, 0);

        for (int i = 0; i < N; i++) begin xs[i] = -256; ws[i] = 256; end
        send_vec(xs, ws, -256, 0);
        recv("neg_bias", -2304, 1'b0, 0);

        for (int i = 0; i < N; i++) begin xs[i] = 32767; ws[i] = 32767; end
        send_vec(xs, ws, 0, 0);
        recv("sat_pos", 32767, 1'b1, 0);

        for (int i = 0; i < N; i++) begin xs[i] = 32767; ws[i] = -32768; end
        send_vec(xs, ws, 0, 0);
        recv("sat_neg", -32768, 1'b1, 0);

        for (int i = 0; i < N; i++) begin xs[i] = 0; ws[i] = 0; end
        xs[0] = 1; ws[0] = 128;
        send_vec(xs, ws, 0, 0);
`ifdef NEURON_MAC_ROUND_EN
        recv("round_half", 1, 1'b0, 0);
`else
        recv("round_half", 0, 1'b0, 0);
`endif

        xs[0] = -1; ws[0] = 128;
        send_vec(xs, ws, 0, 0);
`ifdef NEURON_MAC_ROUND_EN
        recv("round_neg_half", 0, 1'b0, 0);
`else
        recv("round_neg_half", -1, 1'b0, 0);
`endif

        // Mixed values, bubbles between beats, then 5 cycles of backpressure.
        for (int i = 0; i < N; i++) begin xs[i] = 100 * i - 300; ws[i] = 77 + 13 * i; end
        send_vec(xs, ws, 513, 2);
        recv("bubbles_backpressure", model(xs, ws, 513).x, model(xs, ws, 513).sat, 5);

        // Reset after 3 accepted beats discards the partial sum.
        for (int i = 0; i < 3; i++) drive_beat(1000, 1000, 700, 0);
        do_reset();
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        for (int i = 0; i < N; i++) begin xs[i] = 256; ws[i] = 256; end
        send_vec(xs, ws, 0, 0);
        recv("after_rst_unity", 2048, 1'b0, 0);

        // Reset while a result is pending in OUT.
        send_vec(xs, ws, 0, 0);
        repeat (2) @(negedge clk);
        check("pending_out_valid", out_valid, 1);
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_in_ready", in_ready, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
